fpu_cmp_ctrl: RTL and testbench
===============================

# fpu_cmp_ctrl

Sequencing front-end for the FPU's 32-bit comparator datapath. It arbitrates between two requesters (port 0: core FPU issue, port 1: vector/reduction engine) over valid/ready channels and decodes FEQ/FLT/FLE/FMIN/FMAX. It drives the comparator's mode and operands and applies IEEE-754 NaN and signed-zero rules that the raw comparator does not handle. Results land in a one-entry registered response stage with backpressure, tagged with source and request ID.

## Interface
- `ID_W`, default 4, request tag width.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req{0,1}_valid_i`  in  1  request valid.
- `req{0,1}_ready_o`  out  1  request accepted this cycle when valid&ready.
- `req{0,1}_op_i`  in  3  0=FEQ, 1=FLT, 2=FLE, 3=FMIN, 4=FMAX; 5–7 reserved.
- `req{0,1}_a_i`, `req{0,1}_b_i`  in  32  operands, IEEE single.
- `req{0,1}_tag_i`  in  ID_W  request tag.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  consumer ready.
- `rsp_src_o`  out  1  port that issued the response.
- `rsp_tag_o`  out  ID_W  echoed tag.
- `rsp_result_o`  out  32  compares: {31'b0,bit}; min/max: selected operand.
- `rsp_nv_o`  out  1  invalid-operation flag for this response.
- `nv_cnt_o`  out  8  saturating count of responses issued with NV=1.
- `nv_clr_i`  in  1  synchronous clear of `nv_cnt_o`.

## Operation
- Accept enable: `acc = !rsp_valid_q || rsp_ready_i`. `reqN_ready_o = acc && grantN`. Both ready outputs are held 0 while `rst_ni` is low.
- Arbitration is round-robin. Pointer `rr` (reset 0) names the preferred port:
  - Only one port valid: that port is granted.
  - Both ports valid: port `rr` is granted.
  - After any accepted grant to port i, `rr <= ~i`.
  - `rr` is unchanged when nothing is accepted.
- Comparator mode encoding: EQ=2'b10, LT=2'b01, LE=2'b00. 2'b11 is never driven.
  - FEQ uses EQ, FLT uses LT, FLE uses LE.
  - FMIN and FMAX use LT(a,b).
- Classification per operand:
  - NaN: exp==8'hFF and mant!=0.
  - sNaN: NaN with mant[22]=0.
  - zero: bits[30:0]==0.
- FEQ: any NaN gives result 0. NV=1 only if either operand is sNaN. Both operands zero gives result 1, regardless of sign. Otherwise the comparator EQ result.
- FLT/FLE: any NaN gives result 0 and NV=1. Both operands zero gives FLT=0 and FLE=1. Otherwise the comparator result.
- FMIN/FMAX:
  - Both NaN: result 32'h7FC00000.
  - One NaN: result is the other operand.
  - Otherwise FMIN = lt ? a : b, and FMAX = lt ? b : a. The raw LT orders -0 below +0, so FMIN(+0,-0) = -0.
  - NV=1 if either operand is sNaN.
- Reserved op: result 0, NV=1.
- `nv_cnt_o` increments when a response is loaded with NV=1 and saturates at 8'hFF.
  - `nv_clr_i` sets it to 0 and wins over a same-cycle increment.

## Timing
- Latency: a request accepted at edge N is presented with `rsp_valid_o`=1 after edge N.
- Throughput: one request per cycle while `rsp_ready_i`=1.
- While `rsp_valid_o`=1 and `rsp_ready_i`=0, all response outputs hold stable and both ready outputs are 0.
- Same-cycle drain and accept: the response register is reloaded, so `rsp_valid_o` stays 1 with the new contents.
- Drain with no accept: `rsp_valid_o` falls to 0 after the edge.
- Reset values: `rsp_valid_o`=0, `rsp_src_o`=0, `rsp_tag_o`=0, `rsp_result_o`=0, `rsp_nv_o`=0, `nv_cnt_o`=0, `rr`=0.
- Reset asserted mid-operation discards any held response immediately, without waiting for a clock edge.
- Requester-side protocol: a requester holds valid and its payload until accepted. The block does not check for violations.

## Structure
- Shared package `fpu_pkg`: `fcmp_op_e` enum (5 ops), comparator mode constants, `FP32_CANON_NAN` = 32'h7FC00000.
- One sub-module: the existing 32-bit comparator (`CMP_32`), instantiated once and fed by the granted operands.
- Classification and result selection stay inline.

## Test plan
- Port 0 FLT, a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3 -> one cycle later result=1, nv=0, src=0, tag=3.
- FEQ +0/-0 (0x00000000, 0x80000000) -> result=1. FMIN on the same pair -> 0x80000000.
- FLE a=0x7FC00000 (qNaN), b=0x3F800000 -> result 0, nv=1. FEQ on the same pair -> result 0, nv=0. FMAX a=0x7F800001 (sNaN), b=0xBF800000 -> result 0xBF800000, nv=1.
- Both ports valid every cycle for 6 cycles with `rsp_ready_i`=1 -> sources alternate 0,1,0,1,0,1 and no bubbles.
- Hold `rsp_ready_i`=0 for 3 cycles with a response pending -> outputs stable, both ready outputs 0. Then ready=1 -> the next request loads in the same cycle.
- 256 NV responses -> `nv_cnt_o` saturates at 0xFF. `nv_clr_i` together with an NV response -> 0. Assert `rst_ni`=0 with a response pending -> `rsp_valid_o`=0 immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/min-max opcodes, comparator modes and
// IEEE-754 single-precision classification helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } fcmp_op_e;

  localparam logic [1:0]  CMP_EQ = 2'b10;
  localparam logic [1:0]  CMP_LT = 2'b01;
  localparam logic [1:0]  CMP_LE = 2'b00;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp32_is_snan(input logic [31:0] x);
    return fp32_is_nan(x) && !x[22];
  endfunction

  function automatic logic fp32_is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/CMP_32.sv
// Raw 32-bit sign-magnitude comparator. Knows nothing about NaNs and orders
// -0 strictly below +0; the caller layers IEEE semantics on top.
module CMP_32
  import fpu_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        res_o
);

  logic eq;
  logic lt;

  always_comb begin
    eq = (a_i == b_i);
    if (a_i[31] != b_i[31]) begin
      lt = a_i[31];
    end else if (a_i[31]) begin
      lt = a_i[30:0] > b_i[30:0];
    end else begin
      lt = a_i[30:0] < b_i[30:0];
    end

    case (mode_i)
      CMP_EQ:  res_o = eq;
      CMP_LT:  res_o = lt;
      CMP_LE:  res_o = lt || eq;
      default: res_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_cmp_ctrl.sv
// Two-port round-robin front-end for the FP compare datapath: decodes
// FEQ/FLT/FLE/FMIN/FMAX, applies NaN/signed-zero rules, one-entry response.
module fpu_cmp_ctrl
  import fpu_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [2:0]      req0_op_i,
  input  logic [31:0]     req0_a_i,
  input  logic [31:0]     req0_b_i,
  input  logic [ID_W-1:0] req0_tag_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [2:0]      req1_op_i,
  input  logic [31:0]     req1_a_i,
  input  logic [31:0]     req1_b_i,
  input  logic [ID_W-1:0] req1_tag_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_src_o,
  output logic [ID_W-1:0] rsp_tag_o,
  output logic [31:0]     rsp_result_o,
  output logic            rsp_nv_o,
  output logic [7:0]      nv_cnt_o,
  input  logic            nv_clr_i
);

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_src_q, rsp_src_d;
  logic [ID_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_nv_q, rsp_nv_d;
  logic [7:0]      nv_cnt_q, nv_cnt_d;
  logic            rr_q, rr_d;

  logic            acc, grant0, grant1, accept, sel;
  logic [2:0]      sel_op;
  logic [31:0]     sel_a, sel_b;
  logic [ID_W-1:0] sel_tag;
  logic [1:0]      cmp_mode;
  logic            cmp_res;
  logic [31:0]     res;
  logic            res_nv;
  logic            a_nan, b_nan, a_snan, b_snan, any_nan, both_zero;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // here by assigning it first, so no latch is inferred.
  always_comb begin
    acc     = !rsp_valid_q || rsp_ready_i;
    grant0  = req0_valid_i && (!req1_valid_i || !rr_q);
    grant1  = req1_valid_i && (!req0_valid_i || rr_q);
    accept  = acc && (grant0 || grant1);
    sel     = grant1;
    sel_op  = sel ? req1_op_i  : req0_op_i;
    sel_a   = sel ? req1_a_i   : req0_a_i;
    sel_b   = sel ? req1_b_i   : req0_b_i;
    sel_tag = sel ? req1_tag_i : req0_tag_i;
  end

  // Ready is gated by reset directly so it drops without waiting for a clock.
  assign req0_ready_o = rst_ni && acc && grant0;
  assign req1_ready_o = rst_ni && acc && grant1;

  always_comb begin
    case (sel_op)
      OP_FEQ:  cmp_mode = CMP_EQ;
      OP_FLE:  cmp_mode = CMP_LE;
      default: cmp_mode = CMP_LT;
    endcase
  end

  CMP_32 u_cmp (
    .mode_i (cmp_mode),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .res_o  (cmp_res)
  );

  always_comb begin
    a_nan     = fp32_is_nan(sel_a);
    b_nan     = fp32_is_nan(sel_b);
    a_snan    = fp32_is_snan(sel_a);
    b_snan    = fp32_is_snan(sel_b);
    any_nan   = a_nan || b_nan;
    both_zero = fp32_is_zero(sel_a) && fp32_is_zero(sel_b);
    res       = 32'd0;
    res_nv    = 1'b0;

    case (sel_op)
      OP_FEQ: begin
        res_nv = a_snan || b_snan;
        res[0] = !any_nan && (both_zero || cmp_res);
      end
      OP_FLT, OP_FLE: begin
        res_nv = any_nan;
        res[0] = !any_nan && (both_zero ? (sel_op == OP_FLE) : cmp_res);
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = a_snan || b_snan;
        if (a_nan && b_nan)        res = FP32_CANON_NAN;
        else if (a_nan)            res = sel_b;
        else if (b_nan)            res = sel_a;
        else if (sel_op == OP_FMIN) res = cmp_res ? sel_a : sel_b;
        else                       res = cmp_res ? sel_b : sel_a;
      end
      default: res_nv = 1'b1;
    endcase
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_src_d    = rsp_src_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_nv_d     = rsp_nv_q;
    rr_d         = rr_q;
    nv_cnt_d     = nv_cnt_q;

    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_src_d    = sel;
      rsp_tag_d    = sel_tag;
      rsp_result_d = res;
      rsp_nv_d     = res_nv;
      rr_d         = !sel;
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end

    if (nv_clr_i) begin
      nv_cnt_d = 8'd0;
    end else if (accept && res_nv && (nv_cnt_q != 8'hFF)) begin
      nv_cnt_d = nv_cnt_q + 8'd1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= 32'd0;
      rsp_nv_q     <= 1'b0;
      nv_cnt_q     <= 8'd0;
      rr_q         <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_src_q    <= rsp_src_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_nv_q     <= rsp_nv_d;
      nv_cnt_q     <= nv_cnt_d;
      rr_q         <= rr_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_src_o    = rsp_src_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_nv_o     = rsp_nv_q;
  assign nv_cnt_o     = nv_cnt_q;

endmodule

// File: tb/tb_fpu_cmp_ctrl.sv
// Randomized bench for fpu_cmp_ctrl against a value-level IEEE reference model
// plus directed scenarios for arbitration, backpressure, NV counter and reset.
module tb_fpu_cmp_ctrl;

  localparam int ID_W = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req0_valid_i, req0_ready_o;
  logic [2:0]      req0_op_i;
  logic [31:0]     req0_a_i, req0_b_i;
  logic [ID_W-1:0] req0_tag_i;
  logic            req1_valid_i, req1_ready_o;
  logic [2:0]      req1_op_i;
  logic [31:0]     req1_a_i, req1_b_i;
  logic [ID_W-1:0] req1_tag_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_src_o, rsp_nv_o, nv_clr_i;
  logic [ID_W-1:0] rsp_tag_o;
  logic [31:0]     rsp_result_o;
  logic [7:0]      nv_cnt_o;

  fpu_cmp_ctrl #(.ID_W(ID_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_op_i    (req0_op_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_tag_i   (req0_tag_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_op_i    (req1_op_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_tag_i   (req1_tag_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_src_o    (rsp_src_o),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_result_o (rsp_result_o),
    .rsp_nv_o     (rsp_nv_o),
    .nv_cnt_o     (nv_cnt_o),
    .nv_clr_i     (nv_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            v;
    logic [2:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [ID_W-1:0] tag;
  } req_t;

  req_t            pend [2];
  logic            rdy, clr;

  // Model of the observable response register and arbitration preference.
  logic            m_valid, m_src, m_nv, m_rr;
  logic [ID_W-1:0] m_tag;
  logic [31:0]     m_res;
  int              m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Signed numeric key: orders floats by value, with +0 and -0 equal.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic void ref_model(input req_t r, output logic [31:0] res, output logic nv);
    logic an, bn, as, bs;
    longint va, vb;
    an = is_nan(r.a);
    bn = is_nan(r.b);
    as = an && !r.a[22];
    bs = bn && !r.b[22];
    va = fkey(r.a);
    vb = fkey(r.b);
    res = 32'd0;
    case (r.op)
      3'd0: begin nv = as || bs; res[0] = !an && !bn && (va == vb); end
      3'd1: begin nv = an || bn; res[0] = !an && !bn && (va <  vb); end
      3'd2: begin nv = an || bn; res[0] = !an && !bn && (va <= vb); end
      3'd3, 3'd4: begin
        nv = as || bs;
        if (an && bn)      res = 32'h7FC0_0000;
        else if (an)       res = r.b;
        else if (bn)       res = r.a;
        else if (va < vb)  res = (r.op == 3'd3) ? r.a : r.b;
        else if (vb < va)  res = (r.op == 3'd3) ? r.b : r.a;
        else if (r.op == 3'd3) res = r.a[31] ? r.a : r.b;  // min of zeros is -0
        else               res = r.a[31] ? r.b : r.a;      // max of zeros is +0
      end
      default: nv = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [10];
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0001,
           32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001};
    if ($urandom_range(0, 1) == 1) return sp[$urandom_range(0, 9)];
    return $urandom();
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.v   = 1'b1;
    r.op  = 3'($urandom_range(0, 7));
    r.a   = rand_operand();
    r.b   = ($urandom_range(0, 3) == 0) ? r.a : rand_operand();
    r.tag = ID_W'($urandom());
    return r;
  endfunction

  task automatic drive();
    req0_valid_i = pend[0].v; req0_op_i = pend[0].op; req0_a_i = pend[0].a;
    req0_b_i = pend[0].b; req0_tag_i = pend[0].tag;
    req1_valid_i = pend[1].v; req1_op_i = pend[1].op; req1_a_i = pend[1].a;
    req1_b_i = pend[1].b; req1_tag_i = pend[1].tag;
    rsp_ready_i = rdy;
    nv_clr_i = clr;
  endtask

  // One clock cycle: starts and ends 1 time unit after a rising edge.
  task automatic step();
    logic acc, g0, g1, p, nv;
    logic [31:0] res;
    drive();
    #1;
    acc = !m_valid || rdy;
    g0  = pend[0].v && (!pend[1].v || m_rr == 1'b0);
    g1  = pend[1].v && (!pend[0].v || m_rr == 1'b1);
    check("ready0", 32'(req0_ready_o), 32'(acc && g0));
    check("ready1", 32'(req1_ready_o), 32'(acc && g1));
    @(posedge clk_i);
    if (acc && (g0 || g1)) begin
      p = g1;
      ref_model(pend[p], res, nv);
      m_valid = 1'b1; m_src = p; m_tag = pend[p].tag; m_res = res; m_nv = nv;
      if (nv && m_cnt < 255) m_cnt++;
      m_rr = !p;
      pend[p].v = 1'b0;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (clr) m_cnt = 0;
    #1;
    check("rsp_valid", 32'(rsp_valid_o), 32'(m_valid));
    if (m_valid) begin
      check("rsp_src", 32'(rsp_src_o), 32'(m_src));
      check("rsp_tag", 32'(rsp_tag_o), 32'(m_tag));
      check("rsp_result", rsp_result_o, m_res);
      check("rsp_nv", 32'(rsp_nv_o), 32'(m_nv));
    end
    check("nv_cnt", 32'(nv_cnt_o), 32'(m_cnt));
  endtask

  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [ID_W-1:0] tag);
    pend[p] = '{1'b1, op, a, b, tag};
    step();
  endtask

  task automatic reset_model();
    m_valid = 1'b0; m_src = 1'b0; m_tag = '0; m_res = 32'd0; m_nv = 1'b0;
    m_cnt = 0; m_rr = 1'b0;
  endtask

  initial begin
    logic prev_src;
    pend[0] = '{1'b1, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd1};
    pend[1] = '{1'b0, 3'd0, 32'd0, 32'd0, 4'd0};
    rdy = 1'b1; clr = 1'b0;
    reset_model();
    rst_ni = 1'b0;
    drive();
    #2;
    check("rst_ready0", 32'(req0_ready_o), 32'd0);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_src", 32'(rsp_src_o), 32'd0);
    check("rst_tag", 32'(rsp_tag_o), 32'd0);
    check("rst_result", rsp_result_o, 32'd0);
    check("rst_nv", 32'(rsp_nv_o), 32'd0);
    check("rst_cnt", 32'(nv_cnt_o), 32'd0);
    pend[0].v = 1'b0;
    drive();
    #10 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed value cases
    issue(0, 3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd3);
    check("flt_res", rsp_result_o, 32'd1);
    check("flt_nv", 32'(rsp_nv_o), 32'd0);
    check("flt_src", 32'(rsp_src_o), 32'd0);
    check("flt_tag", 32'(rsp_tag_o), 32'd3);
    issue(0, 3'd0, 32'h0000_0000, 32'h8000_0000, 4'd4);
    check("feq_zero", rsp_result_o, 32'd1);
    issue(0, 3'd3, 32'h0000_0000, 32'h8000_0000, 4'd5);
    check("fmin_zero", rsp_result_o, 32'h8000_0000);
    issue(0, 3'd2, 32'h7FC0_0000, 32'h3F80_0000, 4'd6);
    check("fle_qnan_res", rsp_result_o, 32'd0);
    check("fle_qnan_nv", 32'(rsp_nv_o), 32'd1);
    issue(0, 3'd0, 32'h7FC0_0000, 32'h3F80_0000, 4'd7);
    check("feq_qnan_res", rsp_result_o, 32'd0);
    check("feq_qnan_nv", 32'(rsp_nv_o), 32'd0);
    issue(0, 3'd4, 32'h7F80_0001, 32'hBF80_0000, 4'd8);
    check("fmax_snan_res", rsp_result_o, 32'hBF80_0000);
    check("fmax_snan_nv", 32'(rsp_nv_o), 32'd1);

    // Both ports valid every cycle: sources alternate with no bubbles
    prev_src = rsp_src_o;
    for (int i = 0; i < 6; i++) begin
      if (!pend[0].v) pend[0] = rand_req();
      if (!pend[1].v) pend[1] = rand_req();
      step();
      check("alt_src", 32'(rsp_src_o), 32'(!prev_src));
      prev_src = rsp_src_o;
    end

    // Backpressure with a pending response, then release
    if (!pend[0].v) pend[0] = rand_req();
    if (!pend[1].v) pend[1] = rand_req();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b1;
    step();

    // NV counter saturation, then clear against a same-cycle NV response
    pend[1].v = 1'b0;
    for (int i = 0; i < 260; i++) begin
      pend[0] = rand_req();
      pend[0].op = 3'd5;
      step();
    end
    check("nv_sat", 32'(nv_cnt_o), 32'hFF);
    pend[0] = rand_req();
    pend[0].op = 3'd7;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("nv_clr", 32'(nv_cnt_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 9) < 6) pend[p] = rand_req();
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      step();
    end
    clr = 1'b0;

    // Asynchronous reset while a response is held
    rdy = 1'b0;
    pend[1].v = 1'b0;
    issue(0, 3'd6, 32'd0, 32'd0, 4'd9);
    check("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
    pend[0].v = 1'b0;
    drive();
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("async_rst_tag", 32'(rsp_tag_o), 32'd0);
    check("async_rst_cnt", 32'(nv_cnt_o), 32'd0);
    reset_model();
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    issue(0, 3'd1, 32'hBF80_0000, 32'h3F80_0000, 4'd2);
    check("post_rst_flt", rsp_result_o, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
